// File: rtl/image_stream_loader_pkg.sv
// Shared accelerator package: frame geometry defaults and loader FSM states.
// Imported by the pixel loader and its bank RAM.
package image_stream_loader_pkg;

  localparam int NUM_PIXELS_DEF = 784;
  localparam int PIX_W_DEF      = 8;
  localparam int ADDR_W_DEF     = 10;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BUSY      = 2'd1;
  localparam logic [1:0] ST_BUSY_FULL = 2'd2;

endpackage

// File: rtl/image_stream_loader_bank.sv
// One pixel bank: synchronous write port, asynchronous read port.
// Out-of-range reads return zero so no X escapes to the datapath.
module pixel_bank_ram
  import image_stream_loader_pkg::*;
#(
  parameter int DEPTH = NUM_PIXELS_DEF,
  parameter int W     = PIX_W_DEF,
  parameter int AW    = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic         w_rd_ok;
  logic         w_wr_ok;

  assign w_rd_ok = {1'b0, i_raddr} < LIM;
  assign w_wr_ok = {1'b0, i_waddr} < LIM;

  // Pixel storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/image_stream_loader.sv
// Double-buffered image loader: fills one bank from a pixel stream
// while the accelerator reads the other, swapping on frame completion.
module image_stream_loader
  import image_stream_loader_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic              acc_start,
  input  logic              acc_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]        r_state;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_acc_start;
  logic              r_frame_err;
  logic [15:0]       r_frame_count;

  logic              w_accept;
  logic              w_at_last;
  logic              w_complete;
  logic              w_bad;
  logic              w_swap;
  logic [1:0]        w_next;
  logic              w_we0;
  logic              w_we1;
  logic [PIX_W-1:0]  w_rd0;
  logic [PIX_W-1:0]  w_rd1;

  assign s_ready     = (r_state != ST_BUSY_FULL);
  assign w_accept    = s_valid && s_ready;
  assign w_at_last   = (r_wr_cnt == LAST);
  assign w_complete  = w_accept && s_last && w_at_last;
  assign w_bad       = w_accept && (s_last ^ w_at_last);

  // Fill bank is always the one not selected for compute.
  assign w_we0       = w_accept && r_rd_bank;
  assign w_we1       = w_accept && !r_rd_bank;

  assign acc_start   = r_acc_start;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;
  assign rd_pixel    = r_rd_bank ? w_rd1 : w_rd0;

  // Next state and bank-swap decision; a coincident done in BUSY swaps at once.
  always_comb begin
    w_next = r_state;
    w_swap = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_complete) begin
          w_swap = 1'b1;
          w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_complete && acc_done) begin
          w_swap = 1'b1;
        end else if (w_complete) begin
          w_next = ST_BUSY_FULL;
        end else if (acc_done) begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY_FULL: begin
        if (acc_done) begin
          w_swap = 1'b1;
          w_next = ST_BUSY;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Control state, bank select, start pulse and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_rd_bank     <= 1'b0;
      r_acc_start   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state     <= w_next;
      r_acc_start <= w_swap;
      if (w_swap) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // Write pointer; any frame end, good or malformed, rewinds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_accept) begin
        if (s_last || w_at_last) begin
          r_wr_cnt <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  pixel_bank_ram #(
    .DEPTH (NUM_PIXELS),
    .W     (PIX_W),
    .AW    (ADDR_W)
  ) u_bank0 (
    .clk     (clk),
    .i_we    (w_we0),
    .i_waddr (r_wr_cnt),
    .i_wdata (s_data),
    .i_raddr (rd_addr),
    .o_rdata (w_rd0)
  );

  pixel_bank_ram #(
    .DEPTH (NUM_PIXELS),
    .W     (PIX_W),
    .AW    (ADDR_W)
  ) u_bank1 (
    .clk     (clk),
    .i_we    (w_we1),
    .i_waddr (r_wr_cnt),
    .i_wdata (s_data),
    .i_raddr (rd_addr),
    .o_rdata (w_rd1)
  );

endmodule

// File: tb/tb_image_stream_loader.sv
// Bench for image_stream_loader: frame-level reference model,
// per-cycle compare, directed frame scenarios plus random traffic.
module tb_image_stream_loader;

  localparam int N = 784;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [9:0]  rd_addr = '0;
  logic [7:0]  rd_pixel;
  logic        acc_start;
  logic        acc_done = 1'b0;
  logic        frame_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  image_stream_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .rd_addr     (rd_addr),
    .rd_pixel    (rd_pixel),
    .acc_start   (acc_start),
    .acc_done    (acc_done),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp,
               $time);
    end
  endfunction

  // Reference model: frame buffer being filled, frame under compute,
  // accelerator busy flag and a "finished frame waiting" flag.
  logic [7:0] m_fill [N];
  logic [7:0] m_comp [N];
  bit         m_comp_valid = 0;
  int         m_cnt = 0;
  bit         m_running = 0;
  bit         m_pending = 0;
  bit         m_start = 0;
  bit         m_err = 0;
  int         m_count = 0;

  function automatic void model_reset();
    m_cnt = 0;
    m_running = 0;
    m_pending = 0;
    m_start = 0;
    m_err = 0;
    m_count = 0;
    m_comp_valid = 0;
  endfunction

  function automatic void model_edge(bit v, logic [7:0] d, bit l,
                                     bit done);
    bit acc;
    bit comp;
    bit swap;
    acc = v && !m_pending;
    comp = 0;
    swap = 0;
    m_err = 0;
    if (acc) begin
      m_fill[m_cnt] = d;
      if (m_cnt == N-1 && l) comp = 1;
      else if (m_cnt == N-1 || l) m_err = 1;
      m_cnt = (l || m_cnt == N-1) ? 0 : m_cnt + 1;
    end
    if (!m_running) swap = comp;
    else if (m_pending) swap = done;
    else if (comp && done) swap = 1;
    else if (comp) m_pending = 1;
    else if (done) m_running = 0;
    m_start = swap;
    if (swap) begin
      m_comp = m_fill;
      m_comp_valid = 1;
      m_count = (m_count + 1) % 65536;
      m_running = 1;
      m_pending = 0;
    end
  endfunction

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    check("s_ready", 32'(s_ready), 32'(!m_pending));
    check("acc_start", 32'(acc_start), 32'(m_start));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(m_count));
    if (int'(rd_addr) >= N)
      check("rd_pixel_oob", 32'(rd_pixel), 32'd0);
    else if (m_comp_valid)
      check("rd_pixel", 32'(rd_pixel), 32'(m_comp[rd_addr]));
  end

  int n_start = 0;
  int n_err = 0;
  int low_run = 0;
  int max_run = 0;

  // Pulse counters and longest run of s_ready low.
  always @(negedge clk) begin
    if (acc_start === 1'b1) n_start++;
    if (frame_err === 1'b1) n_err++;
    if (s_ready === 1'b0) low_run++;
    else low_run = 0;
    if (low_run > max_run) max_run = low_run;
  end

  logic [7:0] sent [N];

  task automatic step(bit v, logic [7:0] d, bit l, bit done);
    s_valid = v;
    s_data = d;
    s_last = l;
    acc_done = done;
    rd_addr = 10'($urandom_range(1023));
    @(posedge clk);
    if (reset) model_edge(v, d, l, done);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    acc_done = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 8'h00, 0, 0);
  endtask

  task automatic peek(int addr, logic [7:0] exp, string nm);
    rd_addr = 10'(addr);
    #1;
    check(nm, 32'(rd_pixel), 32'(exp));
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    model_reset();
    idle(n);
    reset = 1'b1;
  endtask

  // Streams n accepted pixels; last_idx marks s_last, done_idx raises
  // acc_done together with that pixel, done_pm is random done per mille.
  task automatic send(int n, int last_idx, bit rnd, int done_idx,
                      int gap_pct, int done_pm);
    int i = 0;
    int guard = 0;
    bit v;
    bit rdy;
    bit dn;
    logic [7:0] d;
    while (i < n) begin
      if (guard > 8000) begin
        check("send_timeout", 32'(i), 32'(n));
        return;
      end
      guard++;
      v = ($urandom_range(99) >= gap_pct);
      d = rnd ? 8'($urandom) : 8'(i % 256);
      rdy = !m_pending;
      dn = (v && rdy && i == done_idx) ||
           ($urandom_range(999) < done_pm);
      step(v, d, v && (i == last_idx), dn);
      if (v && rdy) begin
        if (i < N) sent[i] = d;
        i++;
      end
    end
  endtask

  int s0;
  int e0;

  initial begin
    model_reset();
    do_reset(3);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_acc_start", 32'(acc_start), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // Counting-pattern frame into an idle loader.
    s0 = n_start;
    send(N, N-1, 0, -1, 0, 0);
    idle(1);
    check("t036_starts", 32'(n_start - s0), 32'd1);
    check("t036_count", 32'(frame_count), 32'd1);
    peek(300, 8'h2C, "t036_pix300");

    // Second frame while busy: held full until done, then swapped.
    send(N, N-1, 1, -1, 0, 0);
    check("t037_ready_low", 32'(s_ready), 32'd0);
    idle(2);
    check("t037_still_low", 32'(s_ready), 32'd0);
    step(0, 8'h00, 0, 1);
    check("t037_start", 32'(acc_start), 32'd1);
    check("t037_count", 32'(frame_count), 32'd2);
    check("t037_ready", 32'(s_ready), 32'd1);
    peek(5, sent[5], "t037_pix5");
    peek(700, sent[700], "t037_pix700");
    peek(900, 8'h00, "t037_oob");
    step(0, 8'h00, 0, 1);
    idle(2);

    // Early s_last: dropped frame, then a good one.
    s0 = n_start;
    e0 = n_err;
    send(101, 100, 1, -1, 0, 0);
    idle(2);
    check("t038_err", 32'(n_err - e0), 32'd1);
    check("t038_nostart", 32'(n_start - s0), 32'd0);
    send(N, N-1, 1, -1, 0, 0);
    idle(1);
    check("t038_count", 32'(frame_count), 32'd3);
    peek(0, sent[0], "t038_pix0");
    step(0, 8'h00, 0, 1);

    // Missing s_last: dropped frame, counter unchanged, pointer rewound.
    e0 = n_err;
    send(N, -1, 1, -1, 0, 0);
    idle(2);
    check("t039_err", 32'(n_err - e0), 32'd1);
    check("t039_count", 32'(frame_count), 32'd3);
    send(N, N-1, 1, -1, 0, 0);
    idle(1);
    check("t039_next", 32'(frame_count), 32'd4);
    peek(0, sent[0], "t039_pix0");
    peek(N-1, sent[N-1], "t039_pixlast");

    // Completion coinciding with done while busy.
    s0 = n_start;
    max_run = 0;
    send(N, N-1, 1, N-1, 0, 0);
    check("t040_start", 32'(acc_start), 32'd1);
    idle(1);
    check("t040_starts", 32'(n_start - s0), 32'd1);
    check("t040_count", 32'(frame_count), 32'd5);
    check("t040_full_run", 32'(max_run <= 1), 32'd1);
    peek(10, sent[10], "t040_pix10");

    // Reset mid-frame.
    send(400, -1, 1, -1, 0, 0);
    do_reset(2);
    check("t041_ready", 32'(s_ready), 32'd1);
    check("t041_start", 32'(acc_start), 32'd0);
    check("t041_err", 32'(frame_err), 32'd0);
    check("t041_count", 32'(frame_count), 32'd0);
    send(N, N-1, 1, -1, 0, 0);
    idle(1);
    check("t041_count1", 32'(frame_count), 32'd1);
    peek(100, sent[100], "t041_pix100");

    // Random traffic: gaps, random done, occasional malformed frames.
    for (int k = 0; k < 12; k++) begin
      int kind;
      kind = $urandom_range(9);
      if (kind < 7)
        send(N, N-1, 1, -1, 20, 6);
      else if (kind < 9)
        send(N, $urandom_range(N-1), 1, -1, 20, 6);
      else
        send(N, -1, 1, -1, 20, 6);
      for (int j = 0; j < $urandom_range(30); j++)
        step(0, 8'h00, 0, $urandom_range(9) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_stream_loader.md
IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, pixels per frame.
REQ-002 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-003 SHALL have parameter ADDR_W, default 10, pixel address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  upstream pixel valid.
REQ-007 s_data  in  PIX_W  upstream pixel byte, unsigned.
REQ-008 s_last  in  1  marks the final pixel of a frame.
REQ-009 s_ready  out  1  loader can accept a pixel.
REQ-010 rd_addr  in  ADDR_W  pixel address from the accelerator datapath.
REQ-011 rd_pixel  out  PIX_W  pixel at rd_addr in the compute bank, combinational.
REQ-012 acc_start  out  1  one-cycle start pulse to the accelerator controller.
REQ-013 acc_done  in  1  one-cycle completion pulse from the accelerator.
REQ-014 frame_err  out  1  one-cycle pulse when a malformed frame is dropped.
REQ-015 frame_count  out  16  number of frames handed to the accelerator, wraps modulo 2^16.

Function
REQ-016 SHALL hold two banks of NUM_PIXELS x PIX_W: one fill bank and one compute bank, selected by a 1-bit rd_bank register.
REQ-017 SHALL accept a pixel on every cycle with s_valid && s_ready, writing it to fill bank address wr_cnt and then incrementing wr_cnt.
REQ-018 SHALL drive s_ready = 1 unless the fill bank is full and awaiting swap.
REQ-019 SHALL mark a frame complete when a pixel is accepted with wr_cnt == NUM_PIXELS-1 and s_last == 1; wr_cnt then returns to 0.
REQ-020 On s_last with wr_cnt < NUM_PIXELS-1, SHALL pulse frame_err, discard the partial frame, and reset wr_cnt to 0.
REQ-021 On the pixel at wr_cnt == NUM_PIXELS-1 with s_last == 0, SHALL pulse frame_err, discard the frame, and reset wr_cnt to 0.
REQ-022 Control FSM states: IDLE (compute bank free), BUSY (accelerator running), BUSY_FULL (accelerator running, fill bank complete).
REQ-023 IDLE with a frame completing SHALL, on the next edge, toggle rd_bank, pulse acc_start for one cycle, increment frame_count, and enter BUSY.
REQ-024 BUSY with a frame completing SHALL enter BUSY_FULL and hold s_ready = 0.
REQ-025 BUSY on acc_done SHALL enter IDLE.
REQ-026 BUSY_FULL on acc_done SHALL, on the next edge, toggle rd_bank, pulse acc_start, increment frame_count, enter BUSY, and raise s_ready.
REQ-027 If frame completion and acc_done occur in the same cycle in BUSY, SHALL treat it as BUSY_FULL on acc_done (immediate swap and restart).
REQ-028 acc_done in IDLE SHALL be ignored.
REQ-029 The compute bank SHALL never be written while in BUSY or BUSY_FULL.
REQ-030 rd_pixel SHALL be undefined-free for rd_addr >= NUM_PIXELS; it returns 0.
REQ-031 acc_start SHALL be a registered output.

Reset
REQ-032 On reset low, SHALL asynchronously force: state IDLE, rd_bank 0, wr_cnt 0, s_ready 1, acc_start 0, frame_err 0, frame_count 0.
REQ-033 Bank contents SHALL NOT be reset, and any partial frame in progress SHALL be discarded.

Structure
REQ-034 NUM_PIXELS, PIX_W, ADDR_W, and the FSM state encoding SHALL live in the shared accelerator package.
REQ-035 The two banks SHALL be a single sub-module, pixel_bank_ram, with one write port and one asynchronous read port, instantiated twice.

Verification
REQ-036 Stream 784 bytes 0..255 repeating, s_last on byte 784 -> acc_start pulses once, frame_count = 1, rd_pixel at addr 300 = 0x2C.
REQ-037 Stream frame A, then frame B with no acc_done -> after B, s_ready = 0 and state is BUSY_FULL; pulse acc_done -> one cycle later acc_start fires, rd_bank toggles, and rd_pixel shows B data.
REQ-038 Assert s_last on pixel 100 -> frame_err pulses once, no acc_start; the next 784-byte frame loads normally.
REQ-039 Send 784 bytes without s_last -> frame_err pulses, wr_cnt = 0, frame_count unchanged.
REQ-040 In BUSY, the last pixel of frame B coincides with acc_done -> acc_start on the next cycle, and BUSY_FULL is never held for more than 1 cycle.
REQ-041 Drop reset at pixel 400 of a frame -> all outputs return to reset values; a fresh full frame produces frame_count = 1.
